alu_sequencer: RTL and testbench

Multicycle issue/writeback controller sitting directly upstream and downstream of the processor's registered ALU. It accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 4-entry register file. It drives the ALU's `alu_op`/`in1`/`in2`, waits out the ALU's two-stage registered latency (`alu_out`, then `z`), then writes the result back and latches the zero flag.

---
 rtl/alu_sequencer.sv | 119 +++++++++++
 tb/tb_alu_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Issue/writeback controller around the two-stage registered ALU.
// Owns a 4-entry register file and retires one instruction at a time.
module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_z,
    output logic             done,
    output logic             zero_flag,
    output logic             err,
    input  logic [1:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT,
        S_WB,
        S_RETIRE
    } state_t;

    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_SHR = 3'd4;
    localparam logic [2:0] OP_LDI = 3'd5;

    state_t           state;
    logic [WIDTH-1:0] rf [4];
    logic [2:0]       op_q;
    logic [1:0]       rd_q;
    logic [8:0]       imm_q;

    logic [2:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic       is_alu;

    assign opcode = instr[15:13];
    assign rd     = instr[12:11];
    assign rs1    = instr[10:9];
    assign rs2    = instr[8:7];
    assign is_alu = (opcode >= OP_AND) && (opcode <= OP_SHR);

    assign instr_ready = (state == S_IDLE);
    assign dbg_data    = rf[dbg_addr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                rf[i] <= '0;
            end
            op_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            alu_op    <= '0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            zero_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q  <= opcode;
                        rd_q  <= rd;
                        imm_q <= instr[8:0];
                        if (is_alu) begin
                            alu_op  <= opcode;
                            alu_in1 <= rf[rs1];
                            alu_in2 <= rf[rs2];
                            state   <= S_EXEC;
                        end else begin
                            state <= S_RETIRE;
                        end
                    end
                end
                S_EXEC: begin
                    // ALU samples operands on this edge; idle it afterwards
                    alu_op <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    state <= S_WB;
                end
                S_WB: begin
                    rf[rd_q]  <= alu_result;
                    zero_flag <= alu_z;
                    done      <= 1'b1;
                    state     <= S_IDLE;
                end
                S_RETIRE: begin
                    if (op_q == OP_LDI) begin
                        rf[rd_q] <= {{(WIDTH-9){1'b0}}, imm_q};
                    end
                    err   <= op_q[2] & op_q[1];
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a behavioural two-stage ALU and a
// scoreboard of retirements predicted from a register-file model.
module tb_alu_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  alu_op;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [15:0] alu_result;
    logic        alu_z;
    logic        done;
    logic        zero_flag;
    logic        err;
    logic [1:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    alu_sequencer #(.WIDTH(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_op      (alu_op),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_result  (alu_result),
        .alu_z       (alu_z),
        .done        (done),
        .zero_flag   (zero_flag),
        .err         (err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [15:0] alu_f(input logic [2:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        case (op)
            3'd1: return a & b;
            3'd2: return b - a;
            3'd3: return (b >= 16) ? 16'h0 : (a << b[3:0]);
            3'd4: return (b >= 16) ? 16'h0 : (a >> b[3:0]);
            default: return 16'h0;
        endcase
    endfunction

    // Behavioural ALU: alu_out one edge after operands, z one edge later
    logic [15:0] alu_res = '0;
    logic        alu_zr = 1'b0;
    always @(posedge clock) begin
        if (alu_op != 3'd0) alu_res <= alu_f(alu_op, alu_in1, alu_in2);
        alu_zr <= (alu_res == 16'h0);
    end
    assign alu_result = alu_res;
    assign alu_z      = alu_zr;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  rd;
        logic [15:0] val;
        logic        z;
        logic        err;
        int          lat;
        int          issue;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    typedef struct {
        logic [15:0] instr;
        logic [1:0]  rg;
        logic [15:0] val;
        logic        z;
    } vec_t;

    logic [15:0] mrf [4];
    logic        mzf;
    exp_t        sb [$];
    logic [15:0] pend [$];

    function automatic logic [15:0] enc(input logic [2:0] op,
                                        input logic [1:0] rd,
                                        input logic [1:0] rs1,
                                        input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 7'd0};
    endfunction

    function automatic logic [15:0] ldi(input logic [1:0] rd,
                                        input logic [8:0] imm);
        return {3'd5, rd, 2'd0, imm};
    endfunction

    task automatic predict(input logic [15:0] ins, output exp_t e);
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        op  = ins[15:13];
        rd  = ins[12:11];
        rs1 = ins[10:9];
        rs2 = ins[8:7];
        e.rd = rd; e.op = '0; e.a = '0; e.b = '0;
        e.err = 1'b0; e.lat = 1; e.issue = 0;
        if (op >= 3'd1 && op <= 3'd4) begin
            e.op = op;
            e.a = mrf[rs1];
            e.b = mrf[rs2];
            mrf[rd] = alu_f(op, e.a, e.b);
            mzf = (mrf[rd] == 16'h0);
            e.lat = 3;
        end else if (op == 3'd5) begin
            mrf[rd] = {7'd0, ins[8:0]};
        end else if (op >= 3'd6) begin
            e.err = 1'b1;
        end
        e.val = mrf[rd];
        e.z = mzf;
    endtask

    task automatic step();
        exp_t e;
        @(negedge clock);
        if (done) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_done: got 1 expected 0");
            end else begin
                e = sb.pop_front();
                chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                chk("err", 32'(err), 32'(e.err));
                chk("zero_flag", 32'(zero_flag), 32'(e.z));
                dbg_addr = e.rd;
                #1;
                chk("writeback", 32'(dbg_data), 32'(e.val));
            end
        end else begin
            chk("err_no_done", 32'(err), 0);
        end
        if (sb.size() > 0 && cyc == sb[0].issue && sb[0].op != 3'd0) begin
            chk("alu_op", 32'(alu_op), 32'(sb[0].op));
            chk("alu_in1", 32'(alu_in1), 32'(sb[0].a));
            chk("alu_in2", 32'(alu_in2), 32'(sb[0].b));
        end else begin
            chk("alu_op_idle", 32'(alu_op), 0);
        end
        if (pend.size() > 0) begin
            instr = pend[0];
            instr_valid = 1'b1;
        end else begin
            instr = 16'($urandom);
            instr_valid = 1'b0;
        end
        if (instr_valid && instr_ready) begin
            predict(instr, e);
            e.issue = cyc + 1;
            sb.push_back(e);
            void'(pend.pop_front());
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((pend.size() > 0 || sb.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (pend.size() > 0 || sb.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     pend.size() + sb.size());
            pend.delete();
            sb.delete();
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mrf[i] = '0;
        mzf = 1'b0;
        sb.delete();
        pend.delete();
    endtask

    task automatic reset_dut();
        instr_valid = 1'b0;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_in1", 32'(alu_in1), 0);
        chk("rst_in2", 32'(alu_in2), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_zf", 32'(zero_flag), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_ready", 32'(instr_ready), 1);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk("rst_rf", 32'(dbg_data), 0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        pend.push_back(v.instr);
        drain(20);
        dbg_addr = v.rg;
        #1;
        chk("tbl_reg", 32'(dbg_data), 32'(v.val));
        chk("tbl_z", 32'(zero_flag), 32'(v.z));
    endtask

    // Abort a SUB to r3 while in EXEC (ofs 0) or WAIT (ofs 1)
    task automatic reset_mid(input int ofs);
        int n = 0;
        pend.push_back(enc(3'd2, 2'd3, 2'd1, 2'd2));
        while (!(sb.size() > 0 && cyc == sb[0].issue + ofs) && n < 20) begin
            step();
            n++;
        end
        chk("mid_reached", 32'(n < 20), 1);
        reset = 1'b1;
        #1;
        chk("mid_alu_op_async", 32'(alu_op), 0);
        chk("mid_ready", 32'(instr_ready), 1);
        repeat (2) begin
            @(negedge clock);
            chk("mid_done_rst", 32'(done), 0);
        end
        reset = 1'b0;
        model_reset();
        repeat (4) begin
            @(negedge clock);
            chk("mid_done_after", 32'(done), 0);
            chk("mid_alu_op_after", 32'(alu_op), 0);
            chk("mid_ready_after", 32'(instr_ready), 1);
        end
        dbg_addr = 2'd3;
        #1;
        chk("mid_r3", 32'(dbg_data), 0);
    endtask

    vec_t tbl [17];

    initial begin
        tbl[0]  = '{ldi(2'd1, 9'h0F0), 2'd1, 16'h00F0, 1'b0};
        tbl[1]  = '{ldi(2'd2, 9'h0FF), 2'd2, 16'h00FF, 1'b0};
        tbl[2]  = '{enc(3'd2, 2'd3, 2'd1, 2'd2), 2'd3, 16'h000F, 1'b0};
        tbl[3]  = '{ldi(2'd2, 9'h00F), 2'd2, 16'h000F, 1'b0};
        tbl[4]  = '{enc(3'd1, 2'd0, 2'd1, 2'd2), 2'd0, 16'h0000, 1'b1};
        tbl[5]  = '{ldi(2'd0, 9'h0AA), 2'd0, 16'h00AA, 1'b1};
        tbl[6]  = '{enc(3'd2, 2'd0, 2'd1, 2'd1), 2'd0, 16'h0000, 1'b1};
        tbl[7]  = '{ldi(2'd2, 9'h001), 2'd2, 16'h0001, 1'b1};
        tbl[8]  = '{ldi(2'd1, 9'h004), 2'd1, 16'h0004, 1'b1};
        tbl[9]  = '{enc(3'd3, 2'd3, 2'd2, 2'd1), 2'd3, 16'h0010, 1'b0};
        tbl[10] = '{ldi(2'd1, 9'h010), 2'd1, 16'h0010, 1'b0};
        tbl[11] = '{enc(3'd4, 2'd0, 2'd3, 2'd1), 2'd0, 16'h0000, 1'b1};
        tbl[12] = '{ldi(2'd0, 9'h1FF), 2'd0, 16'h01FF, 1'b1};
        tbl[13] = '{enc(3'd6, 2'd0, 2'd1, 2'd2), 2'd0, 16'h01FF, 1'b1};
        tbl[14] = '{enc(3'd7, 2'd1, 2'd0, 2'd0), 2'd1, 16'h0010, 1'b1};
        tbl[15] = '{enc(3'd0, 2'd2, 2'd0, 2'd0), 2'd2, 16'h0001, 1'b1};
        tbl[16] = '{enc(3'd2, 2'd1, 2'd1, 2'd0), 2'd1, 16'h01EF, 1'b0};

        reset_dut();
        for (int i = 0; i < 17; i++) run_vec(tbl[i]);

        // instr_valid held high across busy cycles
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0)
                pend.push_back(ldi(2'($urandom), 9'($urandom)));
            else
                pend.push_back(16'($urandom));
        end
        drain(400);

        reset_dut();
        run_vec('{ldi(2'd1, 9'h005), 2'd1, 16'h0005, 1'b0});
        run_vec('{ldi(2'd2, 9'h009), 2'd2, 16'h0009, 1'b0});
        reset_mid(1);

        run_vec('{ldi(2'd1, 9'h003), 2'd1, 16'h0003, 1'b0});
        run_vec('{ldi(2'd2, 9'h005), 2'd2, 16'h0005, 1'b0});
        reset_mid(0);

        run_vec('{ldi(2'd1, 9'h003), 2'd1, 16'h0003, 1'b0});
        run_vec('{ldi(2'd2, 9'h005), 2'd2, 16'h0005, 1'b0});
        run_vec('{enc(3'd2, 2'd3, 2'd1, 2'd2), 2'd3, 16'h0002, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
